// File: rtl/wb_slot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : wb_slot_scheduler
//  Description : Shares NUM_WB result buses among NUM_REQ issue queues whose
//                functional units have fixed latencies. A time-indexed
//                reservation table records how many buses are already claimed
//                for each future writeback cycle. An issue request is granted
//                only if a bus is still free in the cycle its result arrives.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_slot_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int NUM_WB  = 2,
    parameter int MAX_DLY = 8,
    parameter int LAT_W   = $clog2(MAX_DLY + 1),
    parameter int BUS_W   = $clog2(NUM_WB)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         IN_req,
    input  logic [NUM_REQ*LAT_W-1:0]   IN_lat,
    input  logic                       IN_stall,
    output logic [NUM_REQ-1:0]         OUT_grant,
    output logic [NUM_REQ*BUS_W-1:0]   OUT_grantBus,
    output logic [MAX_DLY-1:0]         OUT_slotFull,
    output logic                       OUT_illegal
);

    // Per-slot occupancy counter must hold 0..NUM_WB inclusive.
    localparam int c_CNT_W = $clog2(NUM_WB + 1);
    localparam int c_RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Scratch table spans every encodable latency so an out-of-range field
    // never indexes outside it; only entries 1..MAX_DLY carry real state.
    localparam int c_LAT_N = 1 << LAT_W;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(NUM_WB);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_CNT_W-1:0]       r_resv [1:MAX_DLY];
    logic [c_RR_W-1:0]        r_rr;
    logic [MAX_DLY-1:0]       r_slot_full;
    logic                     r_illegal;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [LAT_W-1:0]         w_lat [0:NUM_REQ-1];
    logic [NUM_REQ-1:0]       w_lat_ok;
    logic [NUM_REQ-1:0]       w_grant;
    logic [NUM_REQ*BUS_W-1:0] w_grant_bus;
    logic [c_RR_W-1:0]        w_rr_next;
    logic [c_CNT_W-1:0]       w_resv_next [1:MAX_DLY];
    logic [MAX_DLY-1:0]       w_slot_full_next;
    logic                     w_illegal_req;

    // ------------------------------------------------------------------
    // Latency field unpacking and legality (1..MAX_DLY)
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lat
        assign w_lat[gi]    = IN_lat[gi*LAT_W +: LAT_W];
        assign w_lat_ok[gi] = (w_lat[gi] != '0) && (int'(w_lat[gi]) <= MAX_DLY);
    end

    // A request with an unusable latency is flagged even while stalled.
    assign w_illegal_req = |(IN_req & ~w_lat_ok);

    // Round-robin arbitration against the reservation table; also builds
    // the shifted table for the next cycle from the post-grant occupancy.
    always_comb begin : p_arb
        logic [c_CNT_W-1:0] cnt [0:c_LAT_N-1];
        int                 idx;
        w_grant     = '0;
        w_grant_bus = '0;
        w_rr_next   = r_rr;
        idx         = 0;
        for (int d = 0; d < c_LAT_N; d++) begin
            cnt[d] = '0;
        end
        for (int d = 1; d <= MAX_DLY; d++) begin
            cnt[d] = r_resv[d];
        end
        // cnt[L] tracks reservations plus grants already issued this cycle
        // at latency L, so its value is also the lowest free bus index.
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(r_rr) + k) % NUM_REQ;
            if (IN_req[idx] && !IN_stall && !rst && w_lat_ok[idx] &&
                (cnt[w_lat[idx]] < c_FULL)) begin
                w_grant[idx]                     = 1'b1;
                w_grant_bus[idx*BUS_W +: BUS_W]  = cnt[w_lat[idx]][BUS_W-1:0];
                cnt[w_lat[idx]]                  = cnt[w_lat[idx]] + c_CNT_W'(1);
                w_rr_next                        = c_RR_W'((idx + 1) % NUM_REQ);
            end
        end
        // Advance time by one cycle: slot d+1 becomes slot d. Slot 1 (and
        // any L=1 grants) retire; the farthest slot starts empty.
        for (int d = 1; d < MAX_DLY; d++) begin
            w_resv_next[d] = cnt[d+1];
        end
        w_resv_next[MAX_DLY] = '0;
    end

    // Full-slot flags derived from the table as it will be after this edge.
    for (genvar gd = 1; gd <= MAX_DLY; gd++) begin : g_full
        assign w_slot_full_next[gd-1] = (w_resv_next[gd] == c_FULL);
    end

    // Reservation table, round-robin pointer and full-slot view update.
    always_ff @(posedge clk) begin : p_table
        if (rst) begin
            for (int d = 1; d <= MAX_DLY; d++) begin
                r_resv[d] <= '0;
            end
            r_rr        <= '0;
            r_slot_full <= '0;
        end else begin
            for (int d = 1; d <= MAX_DLY; d++) begin
                r_resv[d] <= w_resv_next[d];
            end
            r_rr        <= w_rr_next;
            r_slot_full <= w_slot_full_next;
        end
    end

    // Sticky illegal-latency flag, cleared only by reset.
    always_ff @(posedge clk) begin : p_illegal
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (w_illegal_req) begin
            r_illegal <= 1'b1;
        end
    end

    assign OUT_grant    = w_grant;
    assign OUT_grantBus = w_grant_bus;
    assign OUT_slotFull = r_slot_full;
    assign OUT_illegal  = r_illegal;

endmodule
`default_nettype wire
